// File: rtl/spi_slave_engine_if.sv
// Word stream between the SPI slave engine
// and the register/FIFO layer.
interface spi_slave_engine_if #(
  parameter int N = 8
);
  logic [N-1:0] tx_data_i;
  logic         tx_valid_i;
  logic         tx_ready_o;
  logic [N-1:0] rx_data_o;
  logic         rx_valid_o;

  modport master (
    output tx_data_i,
    output tx_valid_i,
    input  tx_ready_o,
    input  rx_data_o,
    input  rx_valid_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_valid_i,
    output tx_ready_o,
    output rx_data_o,
    output rx_valid_o
  );
endinterface

// File: rtl/spi_slave_engine.sv
// SPI slave datapath in the system clock domain:
// pin sync, edge detect, all CPOL/CPHA modes, TX buffer.
module spi_slave_engine #(
  parameter int           N         = 8,
  parameter bit           CPOL      = 1'b0,
  parameter bit           CPHA      = 1'b0,
  parameter bit           LSB_FIRST = 1'b0,
  parameter logic [N-1:0] FILL      = '1
) (
  input  logic clk_c,
  input  logic reset_rn,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic tx_underrun_o,
  output logic frame_abort_o,
  output logic busy_o,
  spi_slave_engine_if.slave bus
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0] sclk_s;
  logic       sclk_d;
  logic [1:0] cs_s;
  logic [1:0] mosi_s;

  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  rx_sr;
  logic [N-1:0]  rx_nxt;
  logic [N-1:0]  tx_sr;
  logic [N-1:0]  buf_q;
  logic          buf_full;

  logic [N-1:0] rx_data_q;
  logic         rx_valid_q;
  logic         underrun_q;
  logic         abort_q;

  logic lead;
  logic trail;
  logic samp_e;
  logic shft_e;
  logic enter;
  logic leave;
  logic do_samp;
  logic do_shft;
  logic wrap;
  logic load;
  logic accept;

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      sclk_s <= {2{CPOL}};
      sclk_d <= CPOL;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[0], sclk_i};
      sclk_d <= sclk_s[1];
      cs_s   <= {cs_s[0], cs_n_i};
      mosi_s <= {mosi_s[0], mosi_i};
    end
  end

  // leading edge leaves the idle level, trailing edge returns to it
  assign lead   = (sclk_s[1] != CPOL) && (sclk_d == CPOL);
  assign trail  = (sclk_s[1] == CPOL) && (sclk_d != CPOL);
  assign samp_e = CPHA ? trail : lead;
  assign shft_e = CPHA ? lead : trail;

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    leave   = 1'b0;
    do_samp = 1'b0;
    do_shft = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_s[1]) begin
          state_d = SHIFT;
          enter   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s[1]) begin
          state_d = IDLE;
          leave   = 1'b1;
        end else begin
          do_samp = samp_e;
          do_shft = shft_e;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wrap = do_samp && (bit_cnt == CW'(N - 1));

  // CPHA=0 needs the first bit on MISO before the first edge
  assign load = (enter && !CPHA)
             || (do_shft && (bit_cnt == '0));

  assign accept = bus.tx_valid_i && !buf_full;

  assign rx_nxt = LSB_FIRST
                ? {mosi_s[1], rx_sr[N-1:1]}
                : {rx_sr[N-2:0], mosi_s[1]};

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else if (enter || leave) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else if (do_samp) begin
      rx_sr   <= rx_nxt;
      bit_cnt <= wrap ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= wrap;
      if (wrap) begin
        rx_data_q <= rx_nxt;
      end
    end
  end

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      abort_q    <= leave && (bit_cnt != '0);
      underrun_q <= load && !buf_full;
    end
  end

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      tx_sr <= '0;
    end else if (load) begin
      tx_sr <= buf_full ? buf_q : FILL;
    end else if (do_shft) begin
      tx_sr <= LSB_FIRST
             ? {1'b0, tx_sr[N-1:1]}
             : {tx_sr[N-2:0], 1'b0};
    end
  end

  // a load sees the buffer as it was before this cycle's accept
  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else if (load && buf_full) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_q    <= bus.tx_data_i;
      buf_full <= 1'b1;
    end
  end

  assign miso_oe_o = ~cs_s[1];
  assign miso_o    = miso_oe_o
                   & (LSB_FIRST ? tx_sr[0] : tx_sr[N-1]);

  assign busy_o        = (state_q == SHIFT);
  assign tx_underrun_o = underrun_q;
  assign frame_abort_o = abort_q;

  assign bus.tx_ready_o = ~buf_full;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Bench for spi_slave_engine: four mode/bit-order
// instances driven by a bit-level SPI master model.
module tb_spi_slave_engine;

  localparam int N = 8;
  localparam int H = 6;
  localparam logic [N-1:0] FILLV = 8'hFF;

  logic clk_c = 1'b0;
  logic reset_rn;

  always #5 clk_c = ~clk_c;

  logic         sclk[4];
  logic         cs_n[4];
  logic         mosi[4];
  logic         miso[4];
  logic         miso_oe[4];
  logic         urun[4];
  logic         abrt[4];
  logic         busy[4];
  logic [N-1:0] tx_data[4];
  logic         tx_valid[4];
  logic         tx_ready[4];
  logic [N-1:0] rx_data[4];
  logic         rx_valid[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_engine_if #(.N(N)) bus ();

    assign bus.tx_data_i  = tx_data[g];
    assign bus.tx_valid_i = tx_valid[g];
    assign tx_ready[g]    = bus.tx_ready_o;
    assign rx_data[g]     = bus.rx_data_o;
    assign rx_valid[g]    = bus.rx_valid_o;

    spi_slave_engine #(
      .N         (N),
      .CPOL      (g >= 2),
      .CPHA      ((g % 2) == 1),
      .LSB_FIRST ((g % 2) == 1),
      .FILL      (FILLV)
    ) u_dut (
      .clk_c         (clk_c),
      .reset_rn      (reset_rn),
      .sclk_i        (sclk[g]),
      .cs_n_i        (cs_n[g]),
      .mosi_i        (mosi[g]),
      .miso_o        (miso[g]),
      .miso_oe_o     (miso_oe[g]),
      .tx_underrun_o (urun[g]),
      .frame_abort_o (abrt[g]),
      .busy_o        (busy[g]),
      .bus           (bus)
    );
  end

  int n_cmp;
  int n_err;
  int cur;
  int n_rxv[4];
  int n_ur[4];
  int n_ab[4];
  logic [N-1:0] last_rx[4];

  logic [N-1:0] rx_got[$];
  logic [N-1:0] m_tx_q[$];
  logic [N-1:0] m_rx_q[$];
  logic [N-1:0] sup[$];

  function automatic bit cpol(input int i);
    return i >= 2;
  endfunction

  function automatic bit cpha(input int i);
    return (i % 2) == 1;
  endfunction

  function automatic bit lsb(input int i);
    return (i % 2) == 1;
  endfunction

  // loads per frame: one per word, plus the extra
  // trailing-edge load after the last word in CPHA=0
  function automatic int n_loads(
    input int i, input int w,
    input int kab, input bit early
  );
    if (kab > 0) return 1;
    return w + ((!cpha(i) && !early) ? 1 : 0);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk_c) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1) begin
        n_rxv[i]++;
        if (i == cur) rx_got.push_back(rx_data[i]);
      end
      if (urun[i] === 1'b1) n_ur[i]++;
      if (abrt[i] === 1'b1) n_ab[i]++;
    end
  end

  task automatic clr();
    @(posedge clk_c);
    for (int k = 0; k < 4; k++) begin
      n_rxv[k] = 0;
      n_ur[k]  = 0;
      n_ab[k]  = 0;
    end
    rx_got.delete();
  endtask

  task automatic feed();
    int t;
    t = 0;
    while (sup.size() > 0 && t < 4000) begin
      @(negedge clk_c);
      t++;
      if (tx_ready[cur] === 1'b1) begin
        tx_data[cur]  = sup.pop_front();
        tx_valid[cur] = 1'b1;
        @(negedge clk_c);
        tx_valid[cur] = 1'b0;
      end
    end
    chk("feed_left", sup.size(), 0);
  endtask

  task automatic frame(
    input int i, input int w, input int kab,
    input bit early, input bit do_rst
  );
    int nb;
    logic [N-1:0] wd;
    logic [N-1:0] rw;
    nb = (kab > 0) ? kab : w * N;
    wd = '0;
    rw = '0;
    m_rx_q.delete();
    repeat (4) @(negedge clk_c);
    cs_n[i] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      int j;
      int pos;
      j   = b % N;
      pos = lsb(i) ? j : N - 1 - j;
      if (j == 0) begin
        wd = m_tx_q[b / N];
        rw = '0;
      end
      if (!cpha(i)) mosi[i] = wd[pos];
      repeat (H) @(negedge clk_c);
      sclk[i] = ~cpol(i);
      if (cpha(i)) mosi[i] = wd[pos];
      else rw[pos] = miso[i];
      if (b == 0) begin
        chk("busy_mid", busy[i], 1);
        chk("oe_mid", miso_oe[i], 1);
      end
      repeat (H) @(negedge clk_c);
      if (cpha(i) || !(early && b == nb - 1)) begin
        sclk[i] = cpol(i);
        if (cpha(i)) rw[pos] = miso[i];
      end
      if (j == N - 1) m_rx_q.push_back(rw);
    end
    if (do_rst) begin
      #2 reset_rn = 1'b0;
      #1;
      chk("rst_miso", miso[i], 0);
      chk("rst_oe", miso_oe[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_ready", tx_ready[i], 1);
      chk("rst_rxdata", rx_data[i], 0);
      chk("rst_rxvalid", rx_valid[i], 0);
      chk("rst_urun", urun[i], 0);
      chk("rst_abort", abrt[i], 0);
      cs_n[i] = 1'b1;
      sclk[i] = cpol(i);
      repeat (3) @(negedge clk_c);
      reset_rn = 1'b1;
    end else begin
      repeat (H) @(negedge clk_c);
      cs_n[i] = 1'b1;
      if (early && !cpha(i)) begin
        repeat (H) @(negedge clk_c);
        sclk[i] = cpol(i);
      end
    end
    repeat (H + 4) @(negedge clk_c);
  endtask

  task automatic fill(input int w, input int ns);
    m_tx_q.delete();
    sup.delete();
    for (int k = 0; k < w; k++) m_tx_q.push_back(N'($urandom));
    for (int k = 0; k < ns; k++) sup.push_back(N'($urandom));
  endtask

  task automatic run(
    input int i, input int w,
    input int kab, input bit early
  );
    int nl;
    int nu;
    int oth;
    int nrx;
    logic [N-1:0] lw[$];
    nl = n_loads(i, w, kab, early);
    nu = nl - sup.size();
    for (int k = 0; k < nl; k++)
      lw.push_back(k < sup.size() ? sup[k] : FILLV);
    cur = i;
    clr();
    fork
      feed();
      frame(i, w, kab, early, 1'b0);
    join
    nrx = (kab > 0) ? 0 : w;
    chk("rx_count", n_rxv[i], nrx);
    for (int k = 0; k < nrx && k < rx_got.size(); k++)
      chk("rx_word", rx_got[k], m_tx_q[k]);
    chk("miso_count", m_rx_q.size(), nrx);
    for (int k = 0; k < nrx && k < m_rx_q.size(); k++)
      chk("miso_word", m_rx_q[k], lw[k]);
    chk("underrun", n_ur[i], nu);
    chk("abort", n_ab[i], (kab > 0) ? 1 : 0);
    if (kab == 0) last_rx[i] = m_tx_q[w - 1];
    chk("rx_hold", rx_data[i], last_rx[i]);
    chk("ready_end", tx_ready[i], 1);
    chk("busy_end", busy[i], 0);
    chk("oe_end", miso_oe[i], 0);
    chk("miso_end", miso[i], 0);
    oth = 0;
    for (int k = 0; k < 4; k++)
      if (k != i) oth += n_rxv[k] + n_ur[k] + n_ab[k];
    chk("quiet_others", oth, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cur      = 0;
    reset_rn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk[i]     = cpol(i);
      cs_n[i]     = 1'b1;
      mosi[i]     = 1'b0;
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
      last_rx[i]  = '0;
      n_rxv[i]    = 0;
      n_ur[i]     = 0;
      n_ab[i]     = 0;
    end
    repeat (3) @(negedge clk_c);
    for (int i = 0; i < 4; i++) begin
      chk("por_miso", miso[i], 0);
      chk("por_oe", miso_oe[i], 0);
      chk("por_ready", tx_ready[i], 1);
      chk("por_rxdata", rx_data[i], 0);
      chk("por_rxvalid", rx_valid[i], 0);
      chk("por_busy", busy[i], 0);
      chk("por_urun", urun[i], 0);
      chk("por_abort", abrt[i], 0);
    end
    reset_rn = 1'b1;
    repeat (4) @(negedge clk_c);

    m_tx_q = '{8'h3C};
    sup    = '{8'hA5};
    run(0, 1, 0, 1'b0);

    for (int i = 1; i < 4; i++) begin
      m_tx_q = '{8'h81};
      sup    = '{8'h0F};
      run(i, 1, 0, 1'b0);
    end

    fill(3, 0);
    sup = '{8'h11, 8'h22, 8'h33};
    run(0, 3, 0, 1'b0);

    fill(1, 0);
    run(0, 1, 0, 1'b1);

    fill(1, 1);
    run(0, 1, 5, 1'b0);
    fill(1, 1);
    run(0, 1, 0, 1'b0);

    fill(1, 1);
    cur = 0;
    clr();
    fork
      feed();
      frame(0, 1, 3, 1'b0, 1'b1);
    join
    chk("rst_rx_count", n_rxv[0], 0);
    for (int k = 0; k < 4; k++) last_rx[k] = '0;
    fill(1, 1);
    run(0, 1, 0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      int i;
      int w;
      int kab;
      int ns;
      bit e;
      i   = $urandom_range(0, 3);
      w   = $urandom_range(1, 3);
      kab = ($urandom_range(0, 4) == 0)
          ? $urandom_range(1, N - 1) : 0;
      e   = 1'($urandom_range(0, 1));
      ns  = $urandom_range(0, n_loads(i, w, kab, e));
      fill(w, ns);
      run(i, w, kab, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
